ahb_slave_responder: RTL and testbench

AHB_SLAVE_RESPONDER -- requirements
Module: ahb_slave_responder

---
 rtl/ahb_slave_responder.sv | 195 +++++++++++++++++++
 tb/tb_ahb_slave_responder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_responder.sv
// ---------------------------------------------------------------------------
// ahb_slave_responder
//
// AHB-Lite slave backed by a word-organised RAM.
//
// Transfer handling:
//   - Each accepted transfer is classified OKAY or ERROR.
//   - OKAY transfers take WAIT_STATES+1 data-phase cycles.
//   - ERROR transfers use the standard two-cycle ERROR response.
//   - Writes merge into memory with little-endian byte lanes.
//   - A read returns the full addressed word during its final data-phase
//     cycle, and zero at all other times.
//
// Ports:
//   hclk, hresetn    clock, synchronous active-low reset
//   hselx            slave select
//   haddr            byte address (address phase)
//   htrans           IDLE/BUSY/NONSEQ/SEQ
//   hwrite           1 = write
//   hsize            byte / halfword / word
//   hburst           accepted, ignored
//   hprot            accepted, ignored
//   hmastlock        accepted, ignored
//   hready           bus-level ready from the interconnect
//   hwdata           write data (data phase)
//   hreadyout        slave ready
//   hresp            00 OKAY, 01 ERROR
//   hrdata           read data
// ---------------------------------------------------------------------------
module ahb_slave_responder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hselx,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic                  hready,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic                  hreadyout,
  output logic [1:0]            hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LOC_W = IDX_W + 2;
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH * 4);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_LAST,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                state_q, state_d;
  logic [3:0]            wcnt_q, wcnt_d;
  logic                  accept;
  logic                  acc_err;

  logic [LOC_W-1:0]      addr_p1;
  logic [1:0]            size_p1;
  logic                  write_p1;
  logic [IDX_W-1:0]      idx_p1;
  logic [3:0]            be_p1;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  unused_ok;
  assign unused_ok = ^{htrans[0], hburst, hprot, hmastlock};

  // Address-phase classification: range first, then alignment.
  function automatic logic xfer_is_err(input logic [ADDR_WIDTH-1:0] a,
                                       input logic [2:0]            sz);
    logic e;
    e = ({1'b0, a} >= ADDR_LIMIT);
    if (sz > 3'b010)                        e = 1'b1;
    if ((sz == 3'b001) && a[0])             e = 1'b1;
    if ((sz == 3'b010) && (a[1:0] != 2'b00)) e = 1'b1;
    return e;
  endfunction

  // Little-endian byte-lane enables for an OKAY (aligned, in-range) transfer.
  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] en;
    case (sz)
      2'b00:   en = 4'b0001 << a;
      2'b01:   en = a[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  // No new address phase while the slave is stretching (WAIT/ERR1); the bus
  // holds hready low then anyway, this only keeps the FSM safe if it does not.
  assign accept  = hselx && hready && htrans[1] &&
                   ((state_q == ST_IDLE) || (state_q == ST_LAST) || (state_q == ST_ERR2));
  assign acc_err = xfer_is_err(haddr, hsize);

  // ---- stage p0 -> p1: address phase captured into the data phase ----
  always_ff @(posedge hclk) begin
    if (accept) begin
      addr_p1  <= haddr[LOC_W-1:0];
      size_p1  <= hsize[1:0];
      write_p1 <= hwrite;
    end
  end

  assign idx_p1 = addr_p1[LOC_W-1:2];
  assign be_p1  = lane_en(size_p1, addr_p1[1:0]);

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      wcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_LAST, ST_ERR2: begin
        if (accept) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_LAST;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = WS_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 4'd0) begin
          state_d = ST_LAST;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- stage p1 -> memory: write commits on the edge that ends LAST ----
  always_ff @(posedge hclk) begin
    if (hresetn && (state_q == ST_LAST) && write_p1) begin
      for (int b = 0; b < 4; b++) begin
        if (be_p1[b]) begin
          mem[idx_p1][8*b +: 8] <= hwdata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    hrdata    = '0;
    case (state_q)
      ST_WAIT: hreadyout = 1'b0;
      ST_LAST: begin
        if (!write_p1) begin
          hrdata = mem[idx_p1];
        end
      end
      ST_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
      end
      ST_ERR2: hresp = RESP_ERROR;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_slave_responder.sv
module tb_ahb_slave_responder;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NS   = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;
  localparam logic [2:0] SZ_B   = 3'b000;
  localparam logic [2:0] SZ_H   = 3'b001;
  localparam logic [2:0] SZ_W   = 3'b010;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic [1:0]  hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hmastlock;
  logic [31:0] hwdata;
  logic        hreadyout0, hreadyout1;
  logic [1:0]  hresp0, hresp1;
  logic [31:0] hrdata0, hrdata1;

  int checks   = 0;
  int failures = 0;

  always #5 hclk = ~hclk;

  ahb_slave_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(0)
  ) u_dut0 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel[0]), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hready(hreadyout0), .hwdata(hwdata),
    .hreadyout(hreadyout0), .hresp(hresp0), .hrdata(hrdata0)
  );

  ahb_slave_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_STATES(3)
  ) u_dut1 (
    .hclk(hclk), .hresetn(hresetn), .hselx(hsel[1]), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hburst(hburst),
    .hprot(hprot), .hmastlock(hmastlock), .hready(hreadyout1), .hwdata(hwdata),
    .hreadyout(hreadyout1), .hresp(hresp1), .hrdata(hrdata1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic phase(input int dut, input string tag, input logic exp_rdy,
                       input logic [1:0] exp_resp, input logic [31:0] exp_rd);
    logic        rdy;
    logic [1:0]  rsp;
    logic [31:0] rd;
    rdy = (dut == 0) ? hreadyout0 : hreadyout1;
    rsp = (dut == 0) ? hresp0     : hresp1;
    rd  = (dut == 0) ? hrdata0    : hrdata1;
    check({tag, ".hreadyout"}, {31'd0, rdy}, {31'd0, exp_rdy});
    check({tag, ".hresp"},     {30'd0, rsp}, {30'd0, exp_resp});
    check({tag, ".hrdata"},    rd, exp_rd);
  endtask

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic ap(input int dut, input logic [1:0] tr, input logic wr,
                    input logic [31:0] a, input logic [2:0] sz);
    hsel   = (dut == 0) ? 2'b01 : 2'b10;
    htrans = tr;
    hwrite = wr;
    haddr  = a;
    hsize  = sz;
  endtask

  task automatic idle();
    hsel   = 2'b00;
    htrans = T_IDLE;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    hresetn = 1'b0; hsel = 2'b00; haddr = '0; htrans = T_IDLE; hwrite = 1'b0;
    hsize = SZ_W; hburst = 3'b000; hprot = 4'b0011; hmastlock = 1'b0; hwdata = '0;
    repeat (3) tick();
    phase(0, "rst0", 1'b1, 2'b00, 32'h0);
    phase(1, "rst1", 1'b1, 2'b00, 32'h0);
    hresetn = 1'b1;

    // First edge after reset accepts; preload DUT0 with a pipelined write stream.
    ap(0, T_NS, 1'b1, 32'h00, SZ_W); tick();
    phase(0, "first_acc", 1'b1, 2'b00, 32'h0);
    hwdata = 32'h0BADF00D; ap(0, T_NS, 1'b1, 32'h0C, SZ_W); tick();
    hwdata = 32'h0C0C0C0C; ap(0, T_NS, 1'b1, 32'h24, SZ_W); tick();
    hwdata = 32'hCAFEF00D; idle(); tick();

    // Word write then immediate read of the same word.
    ap(0, T_NS, 1'b1, 32'h10, SZ_W); tick();
    phase(0, "wr10", 1'b1, 2'b00, 32'h0);
    hwdata = 32'hDEADBEEF; ap(0, T_NS, 1'b0, 32'h10, SZ_W); tick();
    phase(0, "rd10", 1'b1, 2'b00, 32'hDEADBEEF);
    hwdata = 32'h0; idle(); tick();
    phase(0, "idle10", 1'b1, 2'b00, 32'h0);

    // Byte and halfword lane merges.
    ap(0, T_NS, 1'b1, 32'h20, SZ_W); tick();
    hwdata = 32'h11223344; ap(0, T_NS, 1'b1, 32'h22, SZ_B); tick();
    hwdata = 32'h00AA0000; ap(0, T_NS, 1'b1, 32'h24, SZ_H); tick();
    hwdata = 32'h00001234; ap(0, T_NS, 1'b0, 32'h20, SZ_W); tick();
    phase(0, "byte_merge", 1'b1, 2'b00, 32'h11AA3344);
    ap(0, T_NS, 1'b0, 32'h24, SZ_W); tick();
    phase(0, "half_merge", 1'b1, 2'b00, 32'hCAFE1234);
    ap(0, T_NS, 1'b0, 32'h23, SZ_B); tick();
    phase(0, "byte_rd", 1'b1, 2'b00, 32'h11AA3344);
    idle(); tick();

    // BUSY and deselected transfers are ignored.
    ap(0, T_BUSY, 1'b0, 32'h10, SZ_W); tick();
    phase(0, "busy", 1'b1, 2'b00, 32'h0);
    ap(0, T_NS, 1'b0, 32'h10, SZ_W); hsel = 2'b00; tick();
    phase(0, "nosel", 1'b1, 2'b00, 32'h0);
    idle(); tick();

    // Out-of-range write, then a read issued in ERR2 (pipelined).
    ap(0, T_NS, 1'b1, 32'h400, SZ_W); tick();
    phase(0, "oor_err1", 1'b0, 2'b01, 32'h0);
    hwdata = 32'hFFFFFFFF; idle(); tick();
    phase(0, "oor_err2", 1'b1, 2'b01, 32'h0);
    ap(0, T_NS, 1'b0, 32'h00, SZ_W); tick();
    phase(0, "oor_rd0", 1'b1, 2'b00, 32'h0BADF00D);

    // Misaligned word read.
    ap(0, T_NS, 1'b0, 32'h02, SZ_W); tick();
    phase(0, "mis_err1", 1'b0, 2'b01, 32'h0);
    idle(); tick();
    phase(0, "mis_err2", 1'b1, 2'b01, 32'h0);
    tick();
    phase(0, "mis_idle", 1'b1, 2'b00, 32'h0);

    // Misaligned halfword write and oversize write must not touch memory.
    ap(0, T_NS, 1'b1, 32'h01, SZ_H); tick();
    phase(0, "hmis_err1", 1'b0, 2'b01, 32'h0);
    hwdata = 32'hFFFFFFFF; idle(); tick();
    phase(0, "hmis_err2", 1'b1, 2'b01, 32'h0);
    ap(0, T_NS, 1'b1, 32'h00, 3'b011); tick();
    phase(0, "size_err1", 1'b0, 2'b01, 32'h0);
    idle(); tick();
    phase(0, "size_err2", 1'b1, 2'b01, 32'h0);
    ap(0, T_NS, 1'b0, 32'h00, SZ_W); tick();
    phase(0, "err_rd0", 1'b1, 2'b00, 32'h0BADF00D);

    // Last in-range word.
    ap(0, T_NS, 1'b1, 32'h3FC, SZ_W); tick();
    hwdata = 32'hA5A50FF0; ap(0, T_NS, 1'b0, 32'h3FC, SZ_W); tick();
    phase(0, "top_rd", 1'b1, 2'b00, 32'hA5A50FF0);
    idle(); tick();

    // Back-to-back SEQ bursts, write then read.
    ap(0, T_NS, 1'b1, 32'h30, SZ_W); tick();
    phase(0, "bw0", 1'b1, 2'b00, 32'h0);
    hwdata = 32'h30303030; ap(0, T_SEQ, 1'b1, 32'h34, SZ_W); tick();
    phase(0, "bw1", 1'b1, 2'b00, 32'h0);
    hwdata = 32'h34343434; ap(0, T_SEQ, 1'b1, 32'h38, SZ_W); tick();
    phase(0, "bw2", 1'b1, 2'b00, 32'h0);
    hwdata = 32'h38383838; ap(0, T_NS, 1'b0, 32'h30, SZ_W); tick();
    phase(0, "br0", 1'b1, 2'b00, 32'h30303030);
    ap(0, T_SEQ, 1'b0, 32'h34, SZ_W); tick();
    phase(0, "br1", 1'b1, 2'b00, 32'h34343434);
    ap(0, T_SEQ, 1'b0, 32'h38, SZ_W); tick();
    phase(0, "br2", 1'b1, 2'b00, 32'h38383838);
    idle(); tick();
    phase(0, "b_idle", 1'b1, 2'b00, 32'h0);

    // Reset during LAST of a write: the write is dropped.
    ap(0, T_NS, 1'b1, 32'h0C, SZ_W); tick();
    hwdata = 32'hEEEEEEEE; idle(); hresetn = 1'b0; tick();
    hresetn = 1'b1;
    phase(0, "rst_last", 1'b1, 2'b00, 32'h0);
    ap(0, T_NS, 1'b0, 32'h0C, SZ_W); tick();
    phase(0, "rst_last_rd", 1'b1, 2'b00, 32'h0C0C0C0C);
    idle(); tick();

    // WAIT_STATES=3: two pipelined writes.
    ap(1, T_NS, 1'b1, 32'h04, SZ_W); tick();
    hwdata = 32'h5A5AA5A5; idle();
    for (int i = 0; i < 3; i++) begin
      phase(1, $sformatf("ws_wr_wait%0d", i), 1'b0, 2'b00, 32'h0);
      tick();
    end
    phase(1, "ws_wr_last", 1'b1, 2'b00, 32'h0);
    ap(1, T_NS, 1'b1, 32'h08, SZ_W); tick();
    hwdata = 32'h01020304; idle();
    repeat (3) tick();
    tick();

    // WAIT_STATES=3 read: 3 low cycles then data.
    ap(1, T_NS, 1'b0, 32'h04, SZ_W); tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      phase(1, $sformatf("ws_rd_wait%0d", i), 1'b0, 2'b00, 32'h0);
      tick();
    end
    phase(1, "ws_rd_last", 1'b1, 2'b00, 32'h5A5AA5A5);
    tick();
    phase(1, "ws_rd_idle", 1'b1, 2'b00, 32'h0);

    // Reset during WAIT of a write to 0x08.
    ap(1, T_NS, 1'b1, 32'h08, SZ_W); tick();
    hwdata = 32'hFFFFFFFF; idle();
    phase(1, "rw_wait", 1'b0, 2'b00, 32'h0);
    tick();
    hresetn = 1'b0; tick();
    hresetn = 1'b1;
    phase(1, "rw_after_rst", 1'b1, 2'b00, 32'h0);
    tick();
    phase(1, "rw_idle", 1'b1, 2'b00, 32'h0);
    ap(1, T_NS, 1'b0, 32'h08, SZ_W); tick();
    idle();
    repeat (3) tick();
    phase(1, "rw_rd", 1'b1, 2'b00, 32'h01020304);
    tick();

    // Errors bypass wait states.
    ap(1, T_NS, 1'b0, 32'h400, SZ_W); tick();
    phase(1, "ws_err1", 1'b0, 2'b01, 32'h0);
    idle(); tick();
    phase(1, "ws_err2", 1'b1, 2'b01, 32'h0);
    tick();
    phase(1, "ws_err_idle", 1'b1, 2'b00, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
